// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one request/ready data-memory transaction per memory instruction,
// with pipeline stall, load formatting and timeout abort. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        load_inst,
  input  logic [1:0]  data_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [3:0]  rd_in,
  input  logic        rf_en_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [1:0]  dm_size,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        done,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        mem_fault,
  output logic        align_fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_next_s;
  logic        load_r, rf_en_r, fault_r, align_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [3:0]  rd_r;
  logic [7:0]  cnt_r;
  logic        misalign_s;

  function automatic logic [31:0] fmt_load(input logic [1:0] size, input logic [31:0] rdata);
    case (size)
      2'b00:   fmt_load = {24'h000000, rdata[7:0]};
      2'b01:   fmt_load = {16'h0000, rdata[15:0]};
      default: fmt_load = rdata;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  assign misalign_s = is_misaligned(data_size, addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic; ready has priority over the timeout limit
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_valid) begin
          state_next_s = misalign_s ? ST_DONE : ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dm_ready) begin
          state_next_s = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // instruction latch, wait counter, fault flags and load-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_r  <= 1'b0;
      rf_en_r <= 1'b0;
      fault_r <= 1'b0;
      align_r <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      rd_r    <= 4'h0;
      cnt_r   <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_valid) begin
            load_r  <= load_inst;
            rf_en_r <= rf_en_in;
            size_r  <= data_size;
            addr_r  <= addr;
            wdata_r <= store_data;
            rd_r    <= rd_in;
            cnt_r   <= 8'h00;
            fault_r <= 1'b0;
            align_r <= misalign_s;
          end
        end
        ST_REQ: begin
          if (dm_ready) begin
            rdata_r <= fmt_load(size_r, dm_rdata);
          end else if (cnt_r == CNT_LAST) begin
            fault_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'h01;
          end
        end
        default: ;
      endcase
    end
  end

  assign dm_req      = (state_r == ST_REQ);
  assign dm_we       = (state_r == ST_REQ) & ~load_r;
  assign dm_size     = size_r;
  assign dm_addr     = addr_r;
  assign dm_wdata    = wdata_r;
  assign stall       = ((state_r == ST_IDLE) & mem_valid) | (state_r == ST_REQ);
  assign done        = (state_r == ST_DONE);
  assign wb_valid    = (state_r == ST_DONE) & load_r & rf_en_r & ~fault_r & ~align_r;
  assign wb_data     = rdata_r;
  assign wb_rd       = rd_r;
  assign mem_fault   = (state_r == ST_DONE) & fault_r;
  assign align_fault = (state_r == ST_DONE) & align_r;

endmodule
